// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt pending controller.
package irq_pkg;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  // Default base address of the vector table; each entry is 4 bytes.
  localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0100;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/adder.sv
// Plain W-bit adder, wraps modulo 2^W.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // Unsigned sum, carry out discarded.
  always_comb begin
    sum = a + b;
  end

endmodule

// File: rtl/irq_edge_sync.sv
// Per-line two-flop synchronizer followed by a previous-value flop.
// rise pulses for one cycle when a synchronized line goes from 0 to 1.
module irq_edge_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  // Synchronize the raw lines and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Rising edge of each synchronized line.
  always_comb begin
    rise = sync2 & ~prev;
  end

endmodule

// File: rtl/priority_encoder.sv
// N:1 priority encoder, highest index wins. Output is 0 when disabled or
// when no input is set, so callers needing "any" must compute it themselves.
module priority_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] in,
  input  logic         enable,
  output logic [W-1:0] out
);

  // Scan upward so the highest set index is the one left in out.
  always_comb begin
    out = '0;
    if (enable) begin
      for (int i = 0; i < N; i++) begin
        if (in[i]) out = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: latches rising edges of eight interrupt lines,
// masks them, picks the highest-priority eligible one and presents it to the
// CPU, then tracks it as in service until end-of-interrupt.
//
// Handshake: irq_req is held high with irq_id/irq_vector frozen until the
// cycle in which irq_ack is sampled high; that edge is the transfer, which
// clears the pending bit and enters service. irq_ack outside a request and
// eoi outside service are ignored.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int               VEC_W    = 32,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(VEC_BASE_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       irq_in,
  input  logic             mask_wr,
  input  logic [7:0]       mask_data,
  output logic [7:0]       mask,
  output logic [7:0]       pending,
  output logic             irq_req,
  input  logic             irq_ack,
  output logic [2:0]       irq_id,
  output logic [VEC_W-1:0] irq_vector,
  output logic             in_service,
  input  logic             eoi
);

  irq_state_e       state;
  logic [7:0]       rise;
  logic [7:0]       eligible;
  logic             any;
  logic [ID_W-1:0]  enc_id;
  logic [VEC_W-1:0] vec_offset;
  logic [VEC_W-1:0] vec_sum;
  logic [7:0]       ack_clr;
  logic             ack_take;

  irq_edge_sync #(.W(NUM_IRQ)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .rise  (rise)
  );

  // Masked bits stay pending; only unmasked ones compete.
  always_comb begin
    eligible = pending & ~mask;
    any      = |eligible;
  end

  // Encoder only runs while idle, so a frozen request cannot be retargeted.
  priority_encoder #(.N(NUM_IRQ), .W(ID_W)) u_enc (
    .in     (eligible),
    .enable (state == ST_IDLE),
    .out    (enc_id)
  );

  // Vector table entry offset: 4 bytes per ID.
  always_comb begin
    vec_offset = {{(VEC_W-ID_W-2){1'b0}}, enc_id, 2'b00};
  end

  adder #(.W(VEC_W)) u_vec_add (
    .a   (VEC_BASE),
    .b   (vec_offset),
    .sum (vec_sum)
  );

  // Accepted acknowledge clears exactly the presented ID.
  always_comb begin
    ack_take = (state == ST_REQ) && irq_ack;
    ack_clr  = '0;
    if (ack_take) ack_clr[irq_id] = 1'b1;
  end

  // Pending bits: a new edge wins over a simultaneous clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~ack_clr) | rise;
    end
  end

  // Mask register, writable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= 8'hFF;
    end else if (mask_wr) begin
      mask <= mask_data;
    end
  end

  // Request/service FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      irq_vector <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            irq_id     <= enc_id;
            irq_vector <= vec_sum;
            irq_req    <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            in_service <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          irq_req    <= 1'b0;
          in_service <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed table, hand-written corner sequences
// and randomized traffic, all compared against a behavioural model.
module tb_irq_pending_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_in;
  logic        mask_wr;
  logic [7:0]  mask_data;
  logic [7:0]  mask;
  logic [7:0]  pending;
  logic        irq_req;
  logic        irq_ack;
  logic [2:0]  irq_id;
  logic [31:0] irq_vector;
  logic        in_service;
  logic        eoi;

  int checks = 0;
  int errors = 0;

  irq_pending_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .mask       (mask),
    .pending    (pending),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id),
    .irq_vector (irq_vector),
    .in_service (in_service),
    .eoi        (eoi)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sample history, pending set, request/service flags
  logic [7:0]  h0, h1, h2;
  logic [7:0]  m_mask, m_pend;
  logic        m_req, m_svc;
  logic [2:0]  m_id;
  logic [31:0] m_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] highest(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic model_reset();
    h0 = 0; h1 = 0; h2 = 0;
    m_mask = 8'hFF; m_pend = 0;
    m_req = 0; m_svc = 0; m_id = 0; m_vec = 0;
  endtask

  // One clock edge of the model, using input values seen just before the edge.
  task automatic model_edge();
    logic [7:0] rise_m, elig, clr;
    rise_m = h1 & ~h2;
    elig   = m_pend & ~m_mask;
    clr    = 8'h00;
    if (m_req && irq_ack) begin
      clr   = 8'h01 << m_id;
      m_req = 0;
      m_svc = 1;
    end else if (m_svc && eoi) begin
      m_svc = 0;
    end else if (!m_req && !m_svc && elig != 0) begin
      m_id  = highest(elig);
      m_vec = 32'h100 + 32'(m_id) * 4;
      m_req = 1;
    end
    m_pend = (m_pend & ~clr) | rise_m;
    if (mask_wr) m_mask = mask_data;
    h2 = h1; h1 = h0; h0 = irq_in;
  endtask

  task automatic check_model();
    check("mdl_mask", mask, m_mask);
    check("mdl_pending", pending, m_pend);
    check("mdl_irq_req", irq_req, m_req);
    check("mdl_irq_id", irq_id, m_id);
    check("mdl_irq_vector", irq_vector, m_vec);
    check("mdl_in_service", in_service, m_svc);
  endtask

  // One cycle: model steps on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  // Driver tasks
  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    while (!irq_req && n < budget) begin
      cycle();
      n++;
    end
    check(name, irq_req, 1'b1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    cycle();
    eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_wr = 1'b1;
    mask_data = v;
    cycle();
    mask_wr = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  irq;
    logic        wr;
    logic [7:0]  md;
    logic        ack;
    logic        e;
    logic [7:0]  e_pend;
    logic        e_req;
    logic [2:0]  e_id;
    logic [31:0] e_vec;
    logic        e_svc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Reset block
    rst_n = 1'b0;
    irq_in = 0; mask_wr = 0; mask_data = 0; irq_ack = 0; eoi = 0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mask", mask, 8'hFF);
    check("rst_pending", pending, 8'h00);
    check("rst_irq_req", irq_req, 1'b0);
    check("rst_irq_id", irq_id, 3'd0);
    check("rst_irq_vector", irq_vector, 32'h0);
    check("rst_in_service", in_service, 1'b0);

    // Masked pulse on line 3, unmask, serve; then a held level on line 3
    tbl[0]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 32'h000, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 32'h000, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0, 32'h000, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0, 32'h000, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 8'hF7, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0, 32'h000, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 32'h10C, 1'b0};
    tbl[6]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b1};
    tbl[7]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b1};
    tbl[8]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b0};
    tbl[10] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b0};
    tbl[11] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b0};
    tbl[12] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd3, 32'h10C, 1'b0};
    tbl[13] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 32'h10C, 1'b0};
    tbl[14] = '{8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b1};
    tbl[15] = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b0};
    tbl[16] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 32'h10C, 1'b0};

    for (int i = 0; i < 17; i++) begin
      irq_in = tbl[i].irq; mask_wr = tbl[i].wr; mask_data = tbl[i].md;
      irq_ack = tbl[i].ack; eoi = tbl[i].e;
      cycle();
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
      check($sformatf("tbl%0d_irq_req", i), irq_req, tbl[i].e_req);
      check($sformatf("tbl%0d_irq_id", i), irq_id, tbl[i].e_id);
      check($sformatf("tbl%0d_irq_vector", i), irq_vector, tbl[i].e_vec);
      check($sformatf("tbl%0d_in_service", i), in_service, tbl[i].e_svc);
    end
    irq_in = 0; mask_wr = 0; irq_ack = 0; eoi = 0;
    check("tbl_mask_after", mask, 8'hF7);

    // Lines 1 and 6 together: 6 first, then 1
    write_mask(8'h00);
    irq_in = 8'h42;
    cycle();
    irq_in = 8'h00;
    wait_req("s3_req_a", 10);
    check("s3_id_first", irq_id, 3'd6);
    check("s3_vec_first", irq_vector, 32'h118);
    do_ack();
    do_eoi();
    wait_req("s3_req_b", 5);
    check("s3_id_second", irq_id, 3'd1);
    check("s3_vec_second", irq_vector, 32'h104);
    do_ack();
    do_eoi();

    // Request for 2 is frozen against a higher arrival and against masking
    irq_in = 8'h04;
    cycle();
    irq_in = 8'h00;
    wait_req("s4_req_2", 10);
    check("s4_id_2", irq_id, 3'd2);
    irq_in = 8'h80;
    cycle();
    irq_in = 8'h00;
    for (int i = 0; i < 4; i++) cycle();
    check("s4_id_held", irq_id, 3'd2);
    check("s4_pending_7", pending, 8'h84);
    write_mask(8'h04);
    cycle();
    check("s4_req_kept", irq_req, 1'b1);
    check("s4_id_kept", irq_id, 3'd2);
    do_ack();
    do_eoi();
    wait_req("s4_req_7", 5);
    check("s4_id_7", irq_id, 3'd7);
    check("s4_vec_7", irq_vector, 32'h11C);
    do_ack();
    do_eoi();
    write_mask(8'h00);

    // New edge on line 4 coincides with the ack of id 4: set wins
    irq_in = 8'h10;
    wait_req("s5_req_4", 10);
    check("s5_id_4", irq_id, 3'd4);
    irq_in = 8'h00;
    for (int i = 0; i < 3; i++) cycle();
    irq_in = 8'h10;
    cycle();
    cycle();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check("s5_pending4_kept", pending & 8'h10, 8'h10);
    check("s5_in_service", in_service, 1'b1);
    irq_in = 8'h00;
    do_eoi();
    wait_req("s5_req_4_again", 5);
    check("s5_id_4_again", irq_id, 3'd4);
    do_ack();
    do_eoi();

    // Line 0 alone
    irq_in = 8'h01;
    cycle();
    irq_in = 8'h00;
    wait_req("s5_req_0", 10);
    check("s5_id_0", irq_id, 3'd0);
    check("s5_vec_0", irq_vector, 32'h100);
    do_ack();
    check("s6_in_service_pre", in_service, 1'b1);

    // Asynchronous reset mid-service, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("s6_mask", mask, 8'hFF);
    check("s6_pending", pending, 8'h00);
    check("s6_irq_req", irq_req, 1'b0);
    check("s6_irq_id", irq_id, 3'd0);
    check("s6_irq_vector", irq_vector, 32'h0);
    check("s6_in_service", in_service, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    irq_ack = 1'b1;
    eoi = 1'b1;
    cycle();
    cycle();
    irq_ack = 1'b0;
    eoi = 1'b0;
    check("s6_stray_req", irq_req, 1'b0);
    check("s6_stray_svc", in_service, 1'b0);
    check("s6_stray_pending", pending, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
      mask_wr   = ($urandom_range(0, 19) == 0);
      mask_data = 8'($urandom_range(0, 255));
      if (irq_req) irq_ack = ($urandom_range(0, 2) == 0);
      else         irq_ack = ($urandom_range(0, 9) == 0);
      eoi = ($urandom_range(0, 4) == 0);
      cycle();
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
